sar_search: RTL



---
 rtl/sar_search.sv | 112 +++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation search driving the b operand of a magnitude comparator.
// Optional SAR_EARLY_EXIT_EN: cmp_eq ends the search at that compare.
module sar_search #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cmp_gt,
  input  logic                     cmp_lt,
  input  logic                     cmp_eq,
  output logic [WIDTH-1:0]         guess,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [$clog2(WIDTH):0]   steps,
  output logic                     error
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             error_q, error_d;

  logic             one_hot;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] kept;

  always_comb begin
    one_hot  = (cmp_gt ^ cmp_lt ^ cmp_eq) & ~(cmp_gt & cmp_lt & cmp_eq);
    bit_mask = WIDTH'(1) << idx_q;
    kept     = cmp_lt ? (guess_q & ~bit_mask) : guess_q;

    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          guess_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = IW'(WIDTH - 1);
          steps_d = '0;
          error_d = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        steps_d = steps_q + SW'(1);
        if (!one_hot) begin
          error_d  = 1'b1;
          result_d = guess_q;
          state_d  = S_DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (cmp_eq) begin
          result_d = guess_q;
          state_d  = S_DONE;
        end
`endif
        else if (idx_q != '0) begin
          guess_d = kept | (bit_mask >> 1);
          idx_d   = idx_q - IW'(1);
        end else begin
          // guess is left at the last trial so a zero target never drives 0
          result_d = kept;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      error_q  <= error_d;
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign error  = error_q;
  assign busy   = (state_q == S_COMPARE);
  assign done   = (state_q == S_DONE);

endmodule
